// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot decoder with DIRECT, SCAN and PULSE modes.
// Decodes an SEL_W-bit index onto 2**SEL_W one-hot lines. Every output is a
// flop, so there is no combinational path from any input to any output.
//
//   state (mode_q) | meaning
//   M_DIRECT       | y follows onehot(s) every enabled edge
//   M_SCAN         | idx steps every dwell+1 enabled cycles; wrap on max->0
//   M_PULSE        | load fires a dwell+1 cycle one-hot pulse on onehot(s)
//   M_OFF          | y and busy forced low; idx holds (reset state)
module decoder_seq #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      s,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  load,
  output logic [2**SEL_W-1:0]   y,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  wrap
);

  localparam int N = 2**SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {
    M_DIRECT = 2'b00,
    M_SCAN   = 2'b01,
    M_PULSE  = 2'b10,
    M_OFF    = 2'b11
  } mode_t;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  mode_t               mode_q, mode_n, mode_in;
  logic [DWELL_W-1:0]  cnt, cnt_n;
  logic [SEL_W-1:0]    idx_n, idx_inc;
  logic [N-1:0]        y_n;
  logic                busy_n, wrap_n;
  logic                entry;
  logic                expired;

  assign mode_in = mode_t'(mode);
  assign idx_inc = idx + SEL_W'(1);
  assign expired = (cnt == dwell);

  // State register: synchronous reset wins over enable; en=0 holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= M_OFF;
      cnt    <= '0;
      idx    <= '0;
      y      <= '0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
    end else if (en) begin
      mode_q <= mode_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      y      <= y_n;
      busy   <= busy_n;
      wrap   <= wrap_n;
    end
  end

  // Next-state: mode change clears the sequencing state, then the new mode acts.
  always_comb begin
    mode_n = mode_q;
    cnt_n  = cnt;
    idx_n  = idx;
    y_n    = y;
    busy_n = busy;
    wrap_n = wrap;
    entry  = (mode_in != mode_q);

    if (entry) begin
      cnt_n  = '0;
      busy_n = 1'b0;
      wrap_n = 1'b0;
      mode_n = mode_in;
    end

    case (mode_in)
      M_DIRECT: begin
        idx_n = s;
        y_n   = onehot(s);
      end
      M_SCAN: begin
        if (entry || load) begin
          // A reload beats a dwell expiry, so no wrap is flagged here.
          idx_n  = s;
          cnt_n  = '0;
          y_n    = onehot(s);
          wrap_n = 1'b0;
        end else if (expired) begin
          cnt_n  = '0;
          idx_n  = idx_inc;
          y_n    = onehot(idx_inc);
          wrap_n = (idx == IDX_MAX);
        end else begin
          cnt_n  = cnt + DWELL_W'(1);
          wrap_n = 1'b0;
        end
      end
      M_PULSE: begin
        if (entry) begin
          // The entry edge only clears; a pulse can fire from the next edge.
          y_n    = '0;
          busy_n = 1'b0;
        end else if (busy) begin
          if (expired) begin
            y_n    = '0;
            busy_n = 1'b0;
            cnt_n  = '0;
          end else begin
            cnt_n = cnt + DWELL_W'(1);
          end
        end else if (load) begin
          idx_n  = s;
          y_n    = onehot(s);
          busy_n = 1'b1;
          cnt_n  = '0;
        end
      end
      M_OFF: begin
        y_n    = '0;
        busy_n = 1'b0;
        wrap_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: a vector table for the 2-bit instance,
// hand sequences for reset mid-pulse and a 3-bit parameter sweep.
module tb_decoder_seq;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // SEL_W=2, DWELL_W=8 instance
  logic       rst, en, load;
  logic [1:0] mode, s;
  logic [7:0] dwell;
  logic [3:0] y;
  logic [1:0] idx;
  logic       busy, wrap;

  // SEL_W=3, DWELL_W=2 instance
  logic       rst2, en2, load2;
  logic [1:0] mode2, dwell2;
  logic [2:0] s2, idx2;
  logic [7:0] y2;
  logic       busy2, wrap2;

  decoder_seq #(.SEL_W(2), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .dwell(dwell),
    .load(load), .y(y), .idx(idx), .busy(busy), .wrap(wrap)
  );

  decoder_seq #(.SEL_W(3), .DWELL_W(2)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .s(s2), .dwell(dwell2),
    .load(load2), .y(y2), .idx(idx2), .busy(busy2), .wrap(wrap2)
  );

  typedef struct {
    logic       rst, en;
    logic [1:0] mode, s;
    logic [7:0] dwell;
    logic       load;
    logic [3:0] y;
    logic [1:0] idx;
    logic       busy, wrap;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t v(input logic r, input logic e, input logic [1:0] m,
                             input logic [1:0] sv, input logic [7:0] d, input logic l,
                             input logic [3:0] ey, input logic [1:0] ei,
                             input logic eb, input logic ew);
    vec_t t;
    t.rst = r; t.en = e; t.mode = m; t.s = sv; t.dwell = d; t.load = l;
    t.y = ey; t.idx = ei; t.busy = eb; t.wrap = ew;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [3:0] ey, input logic [1:0] ei,
                      input logic eb, input logic ew);
    chk({tag, " y"},    32'(y),    32'(ey));
    chk({tag, " idx"},  32'(idx),  32'(ei));
    chk({tag, " busy"}, 32'(busy), 32'(eb));
    chk({tag, " wrap"}, 32'(wrap), 32'(ew));
  endtask

  initial begin
    //                r en md s  dw ld    y       idx b  w
    // reset, DIRECT
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 2, 0, 0, 4'b0100, 2, 0, 0));
    vecs.push_back(v(0, 1, 0, 3, 0, 1, 4'b1000, 3, 0, 0));
    // SCAN dwell=1 from s=2
    vecs.push_back(v(0, 1, 1, 2, 1, 0, 4'b0100, 2, 0, 0));
    vecs.push_back(v(0, 1, 1, 2, 1, 0, 4'b0100, 2, 0, 0));
    vecs.push_back(v(0, 1, 1, 2, 1, 0, 4'b1000, 3, 0, 0));
    vecs.push_back(v(0, 1, 1, 2, 1, 0, 4'b1000, 3, 0, 0));
    vecs.push_back(v(0, 1, 1, 2, 1, 0, 4'b0001, 0, 0, 1));
    vecs.push_back(v(0, 1, 1, 2, 1, 0, 4'b0001, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 2, 1, 0, 4'b0010, 1, 0, 0));
    // SCAN dwell=0, mid-scan load, en freeze
    vecs.push_back(v(0, 1, 1, 2, 0, 0, 4'b0100, 2, 0, 0));
    vecs.push_back(v(0, 1, 1, 1, 0, 1, 4'b0010, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, 1, 0, 0, 4'b0100, 2, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(0, 0, 1, 0, 0, 1, 4'b0100, 2, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 4'b1000, 3, 0, 0));
    vecs.push_back(v(0, 1, 1, 3, 0, 1, 4'b1000, 3, 0, 0));
    vecs.push_back(v(0, 1, 1, 3, 0, 0, 4'b0001, 0, 0, 1));
    vecs.push_back(v(0, 0, 1, 3, 0, 0, 4'b0001, 0, 0, 1));
    vecs.push_back(v(0, 1, 1, 3, 0, 0, 4'b0010, 1, 0, 0));
    // PULSE dwell=3
    vecs.push_back(v(0, 1, 2, 0, 3, 0, 4'b0000, 1, 0, 0));
    vecs.push_back(v(0, 1, 2, 0, 3, 1, 4'b0001, 0, 1, 0));
    vecs.push_back(v(0, 1, 2, 2, 3, 1, 4'b0001, 0, 1, 0));
    vecs.push_back(v(0, 1, 2, 2, 3, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(v(0, 1, 2, 2, 3, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(v(0, 1, 2, 3, 3, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(v(0, 1, 2, 3, 3, 1, 4'b1000, 3, 1, 0));
    // abort with OFF, dwell=5
    vecs.push_back(v(0, 1, 2, 3, 5, 0, 4'b1000, 3, 1, 0));
    vecs.push_back(v(0, 1, 2, 3, 5, 0, 4'b1000, 3, 1, 0));
    vecs.push_back(v(0, 1, 3, 3, 5, 0, 4'b0000, 3, 0, 0));
    vecs.push_back(v(0, 1, 3, 0, 5, 1, 4'b0000, 3, 0, 0));

    rst = 1; en = 1; mode = 0; s = 0; dwell = 0; load = 0;
    rst2 = 1; en2 = 1; mode2 = 0; s2 = 0; dwell2 = 0; load2 = 0;
    #1;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
      s = vecs[i].s; dwell = vecs[i].dwell; load = vecs[i].load;
      tick();
      chk1($sformatf("vec%0d", i), vecs[i].y, vecs[i].idx, vecs[i].busy, vecs[i].wrap);
    end

    // Reset mid-pulse: no tail may survive.
    rst = 0; en = 1; mode = 2; s = 1; dwell = 5; load = 0;
    tick(); chk1("rp_entry", 4'b0000, 3, 0, 0);
    load = 1;
    tick(); chk1("rp_fire", 4'b0010, 1, 1, 0);
    load = 0;
    tick(); chk1("rp_mid", 4'b0010, 1, 1, 0);
    rst = 1;
    tick(); chk1("rp_rst", 4'b0000, 0, 0, 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); chk1($sformatf("rp_after%0d", i), 4'b0000, 0, 0, 0);
    end

    // Parameter sweep: SEL_W=3, DWELL_W=2.
    tick();
    chk("sw_rst y", 32'(y2), 32'h00);
    rst2 = 0; mode2 = 1; s2 = 7; dwell2 = 0;
    tick();
    chk("sw_s7 y", 32'(y2), 32'h80);
    chk("sw_s7 idx", 32'(idx2), 32'd7);
    chk("sw_s7 wrap", 32'(wrap2), 32'd0);
    tick();
    chk("sw_wrap y", 32'(y2), 32'h01);
    chk("sw_wrap wrap", 32'(wrap2), 32'd1);
    tick();
    chk("sw_next y", 32'(y2), 32'h02);
    chk("sw_next wrap", 32'(wrap2), 32'd0);
    for (int i = 0; i < 24; i++) begin
      en2 = (i % 3) != 2;
      dwell2 = 2'(i % 4);
      tick();
      chk($sformatf("sw_inv%0d", i), 32'(y2), 32'(8'h01 << idx2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
